// File: rtl/ifetch_stage_pkg.sv
// ifetch_stage_pkg: fetch FSM state encoding and reset constants shared by the
// PC register, the fetch stage and decode.
package ifetch_stage_pkg;
    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_t;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load / bubble / hold controls.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : capture instr/pc as a valid instruction
//   bubble       : insert NOP, clear valid (pc left as is)
//   instr, pc    : incoming fetched word and its address
//   if_id_*      : register contents towards decode
// Neither load nor bubble means hold.
module ifid_reg #(
    parameter logic [31:0] RESET_PC  = ifetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = ifetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= RESET_PC;
            if_id_valid <= 1'b0;
        end else if (bubble) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_instr <= instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch between PC register and decode.
//   clk, reset_n       : clock, synchronous active-low reset
//   pc                 : current PC; pc_plus4 = pc + 4 to next-PC mux
//   hazard, flush      : decode stall / taken branch (flush wins)
//   imem_req/addr/ack/rdata : req/ack instruction memory read
//   pc_en              : one-cycle PC load (delivery or flush)
//   if_id_instr/pc/valid : IF/ID register towards decode
// Optional macro IFETCH_PERF_EN adds perf_fetch_cnt and perf_stall_cnt.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = ifetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = ifetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        hazard,
    input  logic        flush,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        pc_en,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    import ifetch_stage_pkg::*;

    if_state_t   state, state_nx;
    logic        flush_pend;
    logic [31:0] hold_instr;
    logic        ack_req, deliver, bubble;

    assign ack_req  = (state == IF_REQ) && imem_ack;
    // A word reaches IF/ID only when no flush is live or pending and decode can take it.
    assign deliver  = !flush && !hazard && ((ack_req && !flush_pend) || state == IF_HOLD);
    // Decode consumes IF/ID every unstalled cycle, so anything not refilled becomes a bubble.
    assign bubble   = flush || (!hazard && !deliver);
    assign pc_en    = deliver || flush;
    assign pc_plus4 = pc + 32'd4;

    // A flush in IDLE stays in IDLE so the next request uses the branch target, not the stale pc.
    always_comb begin
        state_nx = (state == IF_IDLE) ? (flush ? IF_IDLE : IF_REQ)
                 : (state == IF_REQ)  ? (!imem_ack ? IF_REQ
                                        : (flush || flush_pend || !hazard) ? IF_IDLE : IF_HOLD)
                 : (state == IF_HOLD) ? ((flush || !hazard) ? IF_IDLE : IF_HOLD)
                 : IF_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IF_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            flush_pend <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else begin
            state      <= state_nx;
            imem_req   <= (state_nx == IF_REQ);
            // An outstanding request cannot be cancelled; remember the flush until its ack.
            flush_pend <= (state == IF_REQ) && !imem_ack && (flush || flush_pend);
            if (state == IF_IDLE && !flush)
                imem_addr <= {pc[31:2], 2'b00};
            if (ack_req)
                hold_instr <= imem_rdata;
        end
    end

    ifid_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (deliver),
        .bubble     (bubble),
        .instr      ((state == IF_HOLD) ? hold_instr : imem_rdata),
        .pc         (imem_addr),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (deliver)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == IF_REQ && !imem_ack) || state == IF_HOLD)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
